bitmask_scanner: RTL
====================

// Module: bitmask_scanner
// PURPOSE
//  Expands a WIDTH-bit mask into a stream of set-bit indices, one per cycle, lowest bit first.
//  Reverse direction of the OR-reduction gates: those collapse a vector to "any bit set";
//  this block enumerates which bits are set.
//  Sits between a mask producer (e.g. interrupt/flag register) and an index consumer (dispatcher).
// PARAMETERS
//  WIDTH   8   mask width; power of two, 2..32
//  IW      $clog2(WIDTH)   index width (derived localparam, not overridable)
// PORTS
//  CLK        in   1      single clock, rising edge
//  RST_N      in   1      asynchronous, active-low reset
//  IN_VALID   in   1      mask offered on X
//  IN_READY   out  1      scanner can accept a mask
//  X          in   WIDTH  mask to scan
//  OUT_VALID  out  1      IDX holds a valid set-bit index
//  OUT_READY  in   1      consumer takes IDX this cycle
//  IDX        out  IW     index of current set bit
//  LAST       out  1      qualifies OUT_VALID: this is the highest set bit of the mask
//  ANY        out  1      registered OR of the accepted mask; held until next accept
//  EMPTY      out  1      one-cycle pulse: accepted mask was all zeros
// BEHAVIOUR
//  Reset (RST_N low, async): state IDLE, mask reg 0, IN_READY 1, OUT_VALID 0, IDX 0,
//   LAST 0, ANY 0, EMPTY 0. Reset mid-scan discards remaining bits; no further beats.
//  Handshakes: transfer when VALID & READY on same rising edge. OUT_VALID/IDX/LAST held
//   stable while OUT_VALID & !OUT_READY. IN_READY does not depend on IN_VALID.
//  FSM: IDLE  -- IN_VALID & X!=0 --> SCAN (mask reg <= X, ANY <= 1)
//       IDLE  -- IN_VALID & X==0 --> IDLE (ANY <= 0, EMPTY pulses next cycle, no beats)
//       SCAN  -- beat taken, bits remain --> SCAN (clear lowest set bit in mask reg)
//       SCAN  -- beat taken with LAST=1 --> IDLE
//  IN_READY = 1 in IDLE only. OUT_VALID = 1 in SCAN only (registered state).
//  Latency: accept on edge N -> first IDX valid after edge N; one index per cycle with
//   OUT_READY held high; mask with k set bits occupies k cycles in SCAN.
//  IDX = index of lowest set bit of mask reg; LAST = (mask reg & (mask reg-1)) == 0.
//  No back-to-back overlap: new mask accepted earliest the cycle after the LAST beat.
//  ANY/EMPTY update only on accept; X ignored when not accepted.
//  All-ones mask: WIDTH beats, IDX 0..WIDTH-1, LAST on WIDTH-1.
// CONFIGURATION
//  BITMASK_SCANNER_COUNT_EN defined: adds output COUNT [IW:0] = popcount of accepted
//   mask, registered on accept, reset 0, held until next accept (0 for empty mask).
//  Undefined: COUNT port and popcount logic absent; all other behaviour identical.
// STRUCTURE
//  Package bitscan_pkg: scan_state_t enum {IDLE, SCAN}; function idx_width(w).
//  Sub-module lowest_set_index #(WIDTH): combinational priority encoder,
//   mask -> IDX, plus one-hot of lowest set bit used to clear it.
//  Top: FSM, mask register, ANY/EMPTY/COUNT registers, handshake glue.
// TESTING
//  Reset: RST_N=0 -> IN_READY=1, OUT_VALID=0, ANY=0, EMPTY=0; release with no stimulus -> no beats.
//  X=8'b1010_0100, OUT_READY=1 -> IDX 2,5,7 on consecutive cycles, LAST only on 7, ANY=1.
//  X=8'h00 -> no OUT_VALID, EMPTY high one cycle, ANY=0, IN_READY stays 1.
//  X=8'hFF, OUT_READY toggling 1/0 -> IDX 0..7 in order, each held stable while stalled, LAST on 7.
//  X=8'h81, RST_N low after IDX=0 beat -> all outputs to reset values at once, IDX=7 never emitted.
//  BITMASK_SCANNER_COUNT_EN: X=8'hF0 -> COUNT=4; X=8'h00 -> COUNT=0; exhaustive sweep 0..255 vs reference popcount/index list.

Source files
------------

// File: rtl/bitmask_scanner_pkg.sv
// Shared types and helpers for the bitmask scanner: FSM state encoding and index-width derivation.
package bitscan_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } scan_state_t;

    // Index width for a mask of w bits; a 1-bit mask still needs a 1-bit index.
    function automatic int idx_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/bitmask_scanner_lowest_set_index.sv
// Combinational priority encoder: index of the lowest set bit of a mask, plus that bit as one-hot.
module lowest_set_index
    import bitscan_pkg::*;
#(
    parameter  int WIDTH = 8,
    localparam int IW    = idx_width(WIDTH)
) (
    input  logic [WIDTH-1:0] mask_i,
    output logic [IW-1:0]    idx_o,
    output logic [WIDTH-1:0] onehot_o
);

    // Scan from the top down so the lowest set bit is the last one written.
    always_comb begin
        idx_o = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (mask_i[i]) begin
                idx_o = IW'(i);
            end
        end
    end

    assign onehot_o = mask_i & (~mask_i + WIDTH'(1));

endmodule

// File: rtl/bitmask_scanner.sv
// Expands an accepted mask into one set-bit index per beat, lowest bit first.
// Optional macro BITMASK_SCANNER_COUNT_EN adds a registered popcount output COUNT.
module bitmask_scanner
    import bitscan_pkg::*;
#(
    parameter  int WIDTH = 8,
    localparam int IW    = idx_width(WIDTH)
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [WIDTH-1:0] X,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [IW-1:0]    IDX,
    output logic             LAST,
    output logic             ANY,
    output logic             EMPTY,
`ifdef BITMASK_SCANNER_COUNT_EN
    output logic [IW:0]      COUNT,
`endif
    output scan_state_t      DBG_STATE
);

    // Handshake: a transfer happens on a rising edge where VALID and READY are both high;
    // IN_READY and OUT_VALID come from registered state only, and IDX/LAST stay put while stalled.
    scan_state_t      state_q, state_d;
    logic [WIDTH-1:0] mask_q, mask_d;
    logic             any_q, any_d;
    logic             empty_q, empty_d;
    logic [IW-1:0]    low_idx;
    logic [WIDTH-1:0] low_onehot;
    logic             mask_is_last;

    lowest_set_index #(.WIDTH(WIDTH)) u_lsi (
        .mask_i   (mask_q),
        .idx_o    (low_idx),
        .onehot_o (low_onehot)
    );

    assign mask_is_last = (mask_q & (mask_q - WIDTH'(1))) == '0;

    always_comb begin
        state_d = state_q;
        mask_d  = mask_q;
        any_d   = any_q;
        empty_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (IN_VALID) begin
                    any_d   = |X;
                    empty_d = (X == '0);
                    if (X != '0) begin
                        mask_d  = X;
                        state_d = SCAN;
                    end
                end
            end
            SCAN: begin
                if (OUT_READY) begin
                    mask_d = mask_q & ~low_onehot;
                    if (mask_is_last) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= IDLE;
            mask_q  <= '0;
            any_q   <= 1'b0;
            empty_q <= 1'b0;
        end else begin
            state_q <= state_d;
            mask_q  <= mask_d;
            any_q   <= any_d;
            empty_q <= empty_d;
        end
    end

    assign IN_READY  = (state_q == IDLE);
    assign OUT_VALID = (state_q == SCAN);
    assign IDX       = low_idx;
    assign LAST      = OUT_VALID & mask_is_last;
    assign ANY       = any_q;
    assign EMPTY     = empty_q;
    assign DBG_STATE = state_q;

`ifdef BITMASK_SCANNER_COUNT_EN
    logic [IW:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (IN_READY && IN_VALID) begin
            count_d = '0;
            for (int i = 0; i < WIDTH; i++) begin
                count_d = count_d + {{IW{1'b0}}, X[i]};
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign COUNT = count_q;
`endif

endmodule
